// File: rtl/legv8_multicycle_controller.sv
// Multi-cycle LEGv8 control FSM: latches one instruction per handshake and sequences
// datapath control through DECODE/EXEC/MEM/WB/ERROR, with a bounded memory stall.
module legv8_multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5,
  parameter bit XZR_GUARD   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  output logic        instr_ack,
  input  logic        mem_ready,
  input  logic        zero_flag,
  output logic        mem_read_dm,
  output logic        mem_write_dm,
  output logic        reg_write_rf,
  output logic        mux2,
  output logic        mux3,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  output logic [4:0]  write_reg,
  output logic [1:0]  imm_sel,
  output logic [2:0]  alu_op,
  output logic        pc_write,
  output logic        pc_src,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t           cur_state, nxt_state;
  logic [31:0]      ir;
  logic [CNT_W-1:0] stall_cnt;

  logic is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_cbz, is_b;
  logic is_rtype, is_bad, active, stall_last;
  logic [4:0] rd, rn, rm;
  logic [4:0] wr_addr;
  logic       unused_ir_bits;

  assign rd = ir[4:0];
  assign rn = ir[9:5];
  assign rm = ir[20:16];
  assign unused_ir_bits = ^ir[15:10];

  assign is_add   = (ir[31:21] == 11'b10001011000);
  assign is_sub   = (ir[31:21] == 11'b11001011000);
  assign is_and   = (ir[31:21] == 11'b10001010000);
  assign is_orr   = (ir[31:21] == 11'b10101010000);
  assign is_ldur  = (ir[31:21] == 11'b11111000010);
  assign is_stur  = (ir[31:21] == 11'b11111000000);
  assign is_cbz   = (ir[31:24] == 8'b10110100);
  assign is_b     = (ir[31:26] == 6'b000101);
  assign is_rtype = is_add | is_sub | is_and | is_orr;
  assign is_bad   = ~(is_rtype | is_ldur | is_stur | is_cbz | is_b);

  // ERROR is reached only by an illegal opcode or a MEM timeout, so the latched
  // instruction alone tells the two causes apart.
  assign active = (cur_state == S_DECODE) || (cur_state == S_EXEC) ||
                  (cur_state == S_MEM) || (cur_state == S_WB) || (cur_state == S_ERROR);
  assign stall_last = (stall_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign wr_addr    = (is_rtype | is_ldur) ? rd : 5'd0;
  assign state      = cur_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      ir        <= '0;
      stall_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_IDLE && instr_valid)
        ir <= instruction;
      if (cur_state == S_MEM && !mem_ready && nxt_state == S_MEM)
        stall_cnt <= stall_cnt + 1'b1;
      else
        stall_cnt <= '0;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    instr_ack    = 1'b0;
    mem_read_dm  = 1'b0;
    mem_write_dm = 1'b0;
    reg_write_rf = 1'b0;
    mux2         = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    illegal      = 1'b0;
    timeout_err  = 1'b0;

    case (cur_state)
      S_IDLE: begin
        instr_ack = instr_valid;
        if (instr_valid) nxt_state = S_DECODE;
      end
      S_DECODE: nxt_state = is_bad ? S_ERROR : S_EXEC;
      S_EXEC: begin
        if (is_rtype) begin
          nxt_state = S_WB;
        end else if (is_ldur || is_stur) begin
          nxt_state = S_MEM;
        end else if (is_cbz) begin
          pc_write  = 1'b1;
          pc_src    = zero_flag;
          nxt_state = S_IDLE;
        end else if (is_b) begin
          pc_write  = 1'b1;
          pc_src    = 1'b1;
          nxt_state = S_IDLE;
        end else begin
          nxt_state = S_ERROR;
        end
      end
      S_MEM: begin
        mem_read_dm  = is_ldur;
        mem_write_dm = is_stur;
        // A late mem_ready still completes the access even on the final stall cycle.
        if (mem_ready) begin
          if (is_ldur) begin
            nxt_state = S_WB;
          end else begin
            pc_write  = 1'b1;
            nxt_state = S_IDLE;
          end
        end else if (stall_last) begin
          nxt_state = S_ERROR;
        end
      end
      S_WB: begin
        reg_write_rf = ~(XZR_GUARD && wr_addr == 5'd31);
        mux2         = is_ldur;
        pc_write     = 1'b1;
        nxt_state    = S_IDLE;
      end
      S_ERROR: begin
        illegal     = is_bad;
        timeout_err = ~is_bad;
        pc_write    = 1'b1;
        nxt_state   = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Field and datapath selects are held steady from DECODE until return to IDLE.
  always_comb begin
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd0;
    write_reg  = 5'd0;
    mux3       = 1'b0;
    imm_sel    = 2'b00;
    alu_op     = 3'b000;
    if (active) begin
      read_reg_1 = rn;
      write_reg  = wr_addr;
      mux3       = is_ldur | is_stur;
      if (is_rtype)
        read_reg_2 = rm;
      else if (is_stur || is_cbz)
        read_reg_2 = rd;
      if (is_ldur || is_stur) imm_sel = 2'b01;
      else if (is_cbz)        imm_sel = 2'b10;
      else if (is_b)          imm_sel = 2'b11;
      if (is_sub)      alu_op = 3'b001;
      else if (is_and) alu_op = 3'b010;
      else if (is_orr) alu_op = 3'b011;
      else if (is_cbz) alu_op = 3'b100;
    end
  end

endmodule

// File: tb/tb_legv8_multicycle_controller.sv
// Directed bench: a per-instruction trace model predicts every output on every cycle.
module tb_legv8_multicycle_controller;

  localparam int TMO = 16;

  typedef struct packed {
    logic       ack, mrd, mwr, rw, mux2, mux3;
    logic [4:0] rr1, rr2, wr;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       pcw, pcs;
    logic [2:0] st;
    logic       ill, to;
  } out_t;

  typedef enum {K_ADD, K_SUB, K_AND, K_ORR, K_LDUR, K_STUR, K_CBZ, K_B, K_BAD} kind_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        instr_valid = 1'b0, mem_ready = 1'b0, zero_flag = 1'b0;
  logic        instr_ack, mem_read_dm, mem_write_dm, reg_write_rf, mux2, mux3;
  logic [4:0]  read_reg_1, read_reg_2, write_reg;
  logic [1:0]  imm_sel;
  logic [2:0]  alu_op, state;
  logic        pc_write, pc_src, illegal, timeout_err;

  int checks = 0;
  int fails  = 0;
  out_t  trace[$];
  out_t  exp_q[$];
  string tag_q[$];
  out_t  act;

  legv8_multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(5), .XZR_GUARD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ack(instr_ack), .mem_ready(mem_ready), .zero_flag(zero_flag),
    .mem_read_dm(mem_read_dm), .mem_write_dm(mem_write_dm), .reg_write_rf(reg_write_rf),
    .mux2(mux2), .mux3(mux3), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .write_reg(write_reg), .imm_sel(imm_sel), .alu_op(alu_op), .pc_write(pc_write),
    .pc_src(pc_src), .state(state), .illegal(illegal), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb act = {instr_ack, mem_read_dm, mem_write_dm, reg_write_rf, mux2, mux3,
                     read_reg_1, read_reg_2, write_reg, imm_sel, alu_op,
                     pc_write, pc_src, state, illegal, timeout_err};

  function automatic kind_t classify(input logic [31:0] w);
    logic [10:0] op;
    op = w[31:21];
    if (op == 11'h458) return K_ADD;
    if (op == 11'h658) return K_SUB;
    if (op == 11'h450) return K_AND;
    if (op == 11'h550) return K_ORR;
    if (op == 11'h7C2) return K_LDUR;
    if (op == 11'h7C0) return K_STUR;
    if (w[31:24] == 8'hB4) return K_CBZ;
    if (w[31:26] == 6'b000101) return K_B;
    return K_BAD;
  endfunction

  // Builds the whole expected cycle trace of one instruction, starting at its IDLE/ack cycle.
  function automatic void build(input logic [31:0] w, input bit zf, input int ready_at);
    kind_t k;
    out_t  b, e;
    bit    rtype;
    k = classify(w);
    rtype = (k == K_ADD) || (k == K_SUB) || (k == K_AND) || (k == K_ORR);
    trace.delete();
    e = '0; e.ack = 1'b1;
    trace.push_back(e);
    b = '0;
    b.rr1 = w[9:5];
    if (rtype) b.rr2 = w[20:16];
    if (k == K_STUR || k == K_CBZ) b.rr2 = w[4:0];
    if (rtype || k == K_LDUR) b.wr = w[4:0];
    b.mux3 = (k == K_LDUR || k == K_STUR);
    case (k)
      K_LDUR, K_STUR: b.imm = 2'd1;
      K_CBZ:          b.imm = 2'd2;
      K_B:            b.imm = 2'd3;
      default:        b.imm = 2'd0;
    endcase
    case (k)
      K_SUB:   b.alu = 3'd1;
      K_AND:   b.alu = 3'd2;
      K_ORR:   b.alu = 3'd3;
      K_CBZ:   b.alu = 3'd4;
      default: b.alu = 3'd0;
    endcase
    e = b; e.st = 3'd1; trace.push_back(e);
    if (k == K_BAD) begin
      e = b; e.st = 3'd5; e.ill = 1'b1; e.pcw = 1'b1; trace.push_back(e);
      return;
    end
    e = b; e.st = 3'd2;
    if (k == K_CBZ) begin e.pcw = 1'b1; e.pcs = zf; end
    if (k == K_B)   begin e.pcw = 1'b1; e.pcs = 1'b1; end
    trace.push_back(e);
    if (rtype) begin
      e = b; e.st = 3'd4; e.rw = (b.wr != 5'd31); e.pcw = 1'b1; trace.push_back(e);
    end
    if (k == K_LDUR || k == K_STUR) begin
      for (int j = 1; j <= TMO; j++) begin
        e = b; e.st = 3'd3; e.mrd = (k == K_LDUR); e.mwr = (k == K_STUR);
        if (j == ready_at) begin
          if (k == K_STUR) e.pcw = 1'b1;
          trace.push_back(e);
          if (k == K_LDUR) begin
            e = b; e.st = 3'd4; e.mux2 = 1'b1; e.rw = (b.wr != 5'd31); e.pcw = 1'b1;
            trace.push_back(e);
          end
          break;
        end
        trace.push_back(e);
        if (j == TMO) begin
          e = b; e.st = 3'd5; e.to = 1'b1; e.pcw = 1'b1; trace.push_back(e);
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    out_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t, act, act.st, e, e.st);
      end
    end
  end

  task automatic pin(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic expect_cycle(input out_t e, input string nm);
    exp_q.push_back(e);
    tag_q.push_back(nm);
  endtask

  // rst_at: trace cycle index during which rst_n is pulled low (-1 = never).
  task automatic run(input string nm, input logic [31:0] w, input bit zf,
                     input int ready_at, input int rst_at);
    int n, mem_idx;
    build(w, zf, ready_at);
    n = trace.size();
    if (rst_at >= 0 && rst_at < n) n = rst_at + 1;
    mem_idx = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instr_valid = 1'b1;
      instruction = (i == 0) ? w : 32'hDEADBEEF;
      zero_flag   = zf;
      if (trace[i].st == 3'd3) mem_idx++;
      mem_ready = (trace[i].st == 3'd3) && (mem_idx == ready_at);
      rst_n     = (i != rst_at);
      expect_cycle(trace[i], $sformatf("%s_c%0d", nm, i));
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    rst_n       = 1'b1;
    expect_cycle('0, {nm, "_idle"});
  endtask

  initial begin
    build(32'hCB030046, 1'b0, 0);
    pin("sub_len", trace.size(), 4);
    pin("sub_alu", trace[2].alu, 1);
    pin("sub_wb", {trace[3].rw, trace[3].wr, trace[3].rr1, trace[3].rr2, trace[3].pcw},
        {1'b1, 5'd6, 5'd2, 5'd3, 1'b1});
    build(32'hF840C002, 1'b0, 3);
    pin("ldur_len", trace.size(), 7);
    pin("ldur_wb", {trace[6].mux2, trace[6].rw, trace[6].wr}, {1'b1, 1'b1, 5'd2});
    build(32'hF8008023, 1'b0, 0);
    pin("stur_tmo_len", trace.size(), 20);
    pin("stur_tmo_err", {trace[19].to, trace[19].pcw, trace[19].rw}, 3'b110);
    build(32'hB4000105, 1'b1, 0);
    pin("cbz_exec", {trace[2].pcw, trace[2].pcs, trace[2].rr2, trace[2].imm}, {2'b11, 5'd5, 2'd2});
    build(32'h0000_0000, 1'b0, 0);
    pin("bad_err", {trace.size(), trace[2].ill, trace[2].st}, {32'd3, 1'b1, 3'd5});

    rst_n = 1'b0;
    @(posedge clk); #1;
    expect_cycle('0, "reset0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_cycle('0, "reset1");

    run("sub",      32'hCB030046, 1'b0, 0,   -1);
    run("ldur",     32'hF840C002, 1'b0, 3,   -1);
    run("stur_tmo", 32'hF8008023, 1'b0, 0,   -1);
    run("stur_ok",  32'hF8008023, 1'b0, 2,   -1);
    run("stur_edge",32'hF8008023, 1'b0, TMO, -1);
    run("cbz_z1",   32'hB4000105, 1'b1, 0,   -1);
    run("cbz_z0",   32'hB4000105, 1'b0, 0,   -1);
    run("b",        32'h14000010, 1'b0, 0,   -1);
    run("illegal",  32'h00000000, 1'b0, 0,   -1);
    run("add_xzr",  32'h8B02003F, 1'b0, 0,   -1);
    run("and",      32'h8A0600A4, 1'b0, 0,   -1);
    run("orr",      32'hAA090107, 1'b1, 0,   -1);
    run("ldur_rst", 32'hF840C002, 1'b0, 0,   4);
    run("add_post", 32'h8B030041, 1'b0, 0,   -1);

    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
